// File: rtl/cmp_result_window_monitor.sv
// Windowed statistics over the 4-bit comparator's result flags, summary held on a valid/ready port.
// Optional flag-vs-operand cross-check is built only when CMP_MONITOR_CHECK_EN is defined.
module cmp_result_window_monitor #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       a_i,
    input  logic [3:0]       b_i,
    input  logic             a_gt_b_i,
    input  logic             a_lt_b_i,
    input  logic             a_eq_b_i,
    output logic [CNT_W-1:0] gt_cnt_o,
    output logic [CNT_W-1:0] lt_cnt_o,
    output logic [CNT_W-1:0] eq_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o,
    output logic [CNT_W-1:0] max_eq_run_o,
    output logic [CNT_W-1:0] mism_cnt_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int SW = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    smp_q, smp_d, smp_inc;
    logic [CNT_W-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d, bad_q, bad_d;
    logic [CNT_W-1:0] run_q, run_d, max_q, max_d, run_nxt;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [2:0]       flags;
    logic             accept, wipe, mism_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign flags   = {a_gt_b_i, a_lt_b_i, a_eq_b_i};
    assign accept  = in_valid_i && in_ready_o;
    assign wipe    = clear_i || (state_q == DONE && out_ready_i);
    assign smp_inc = smp_q + 1'b1;
    assign run_nxt = sat_inc(run_q);

`ifdef CMP_MONITOR_CHECK_EN
    // Flags are trusted for classification; this only flags disagreement with the operands.
    always_comb begin
        mism_hit = 1'b0;
        case (flags)
            3'b100:  mism_hit = !(a_i > b_i);
            3'b010:  mism_hit = !(a_i < b_i);
            3'b001:  mism_hit = !(a_i == b_i);
            default: mism_hit = 1'b0;
        endcase
    end
`else
    logic unused_operands;
    assign unused_operands = ^{a_i, b_i};
    assign mism_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        bad_d   = bad_q;
        run_d   = run_q;
        max_d   = max_q;
        mism_d  = mism_q;
        if (wipe) begin
            state_d = IDLE;
            smp_d   = '0;
            gt_d    = '0;
            lt_d    = '0;
            eq_d    = '0;
            bad_d   = '0;
            run_d   = '0;
            max_d   = '0;
            mism_d  = '0;
        end else if (accept) begin
            smp_d   = smp_inc;
            state_d = (smp_inc == SW'(WIN_LEN)) ? DONE : ACC;
            run_d   = '0;
            case (flags)
                3'b100: gt_d = sat_inc(gt_q);
                3'b010: lt_d = sat_inc(lt_q);
                3'b001: begin
                    eq_d  = sat_inc(eq_q);
                    run_d = run_nxt;
                    if (run_nxt > max_q) max_d = run_nxt;
                end
                default: bad_d = sat_inc(bad_q);
            endcase
            if (mism_hit) mism_d = sat_inc(mism_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            smp_q   <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            eq_q    <= '0;
            bad_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            mism_q  <= '0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            bad_q   <= bad_d;
            run_q   <= run_d;
            max_q   <= max_d;
            mism_q  <= mism_d;
        end
    end

    assign in_ready_o   = (state_q != DONE);
    assign out_valid_o  = (state_q == DONE);
    assign gt_cnt_o     = gt_q;
    assign lt_cnt_o     = lt_q;
    assign eq_cnt_o     = eq_q;
    assign bad_cnt_o    = bad_q;
    assign max_eq_run_o = max_q;
    assign mism_cnt_o   = mism_q;

endmodule

// File: tb/tb_cmp_result_window_monitor.sv
// Bench for cmp_result_window_monitor: directed scenarios plus random windows vs a queue-based model.
module tb_cmp_result_window_monitor;
    localparam int WIN = 16;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst, clear, in_valid, out_ready;
    logic [3:0]    a, b;
    logic          gt, lt, eq;
    logic          in_ready, out_valid;
    logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt, bad_cnt, max_eq_run, mism_cnt;

    cmp_result_window_monitor #(.WIN_LEN(WIN), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .a_gt_b_i(gt), .a_lt_b_i(lt), .a_eq_b_i(eq),
        .gt_cnt_o(gt_cnt), .lt_cnt_o(lt_cnt), .eq_cnt_o(eq_cnt), .bad_cnt_o(bad_cnt),
        .max_eq_run_o(max_eq_run), .mism_cnt_o(mism_cnt),
        .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Samples accepted in the current window, in order.
    logic [2:0] qf[$];
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [6*CW-1:0] exp_v, got_v;

    // Expected summary straight from the window's sample list.
    task automatic model();
        int g = 0, l = 0, e = 0, bd = 0, run = 0, mx = 0, mm = 0;
        for (int i = 0; i < qf.size(); i++) begin
            if (qf[i] == 3'b001) begin
                e++;
                run++;
                if (run > mx) mx = run;
            end else begin
                run = 0;
                if (qf[i] == 3'b100) g++;
                else if (qf[i] == 3'b010) l++;
                else bd++;
            end
`ifdef CMP_MONITOR_CHECK_EN
            if ((qf[i] == 3'b100 && !(qa[i] > qb[i])) || (qf[i] == 3'b010 && !(qa[i] < qb[i])) ||
                (qf[i] == 3'b001 && qa[i] != qb[i]))
                mm++;
`endif
        end
        exp_v = {CW'(g), CW'(l), CW'(e), CW'(bd), CW'(mx), CW'(mm)};
    endtask

    function automatic logic [6*CW-1:0] got();
        return {gt_cnt, lt_cnt, eq_cnt, bad_cnt, max_eq_run, mism_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        qf.delete(); qa.delete(); qb.delete();
    endtask

    task automatic send(input logic [2:0] f, input logic [3:0] va, input logic [3:0] vb);
        int t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b expected 1", in_ready);
        end
        {gt, lt, eq} = f; a = va; b = vb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        qf.push_back(f); qa.push_back(va); qb.push_back(vb);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        clr_q();
    endtask

    function automatic logic [2:0] rel(input logic [3:0] va, input logic [3:0] vb);
        return (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
    endfunction

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; {gt, lt, eq} = 3'b000;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (got() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state counts=%h ov=%0b ir=%0b expected 0/0/1", got(), out_valid, in_ready);
        end
        send(3'b100, 4'd9, 4'd3);
        checks++;
        if (gt_cnt !== 8'd1) begin
            errors++; $display("FAIL first_accept gt_cnt=%0d expected 1", gt_cnt);
        end
        clear = 1'b1; tick(); clear = 1'b0; clr_q();
    endtask

    task automatic test_directed();
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL early_valid out_valid=%0b expected 0", out_valid);
                end
            end
            if (i < 6) send(3'b100, 4'd9, 4'd3);
            else if (i < 10) send(3'b010, 4'd2, 4'd7);
            else send(3'b001, 4'd5, 4'd5);
        end
        model();
        checks++;
        if (out_valid !== 1'b1 || got() !== exp_v) begin
            errors++; $display("FAIL directed_summary ov=%0b got=%h expected 1 %h", out_valid, got(), exp_v);
        end
        checks++;
        if (max_eq_run !== 8'd6 || gt_cnt !== 8'd6 || lt_cnt !== 8'd4) begin
            errors++; $display("FAIL directed_const gt=%0d lt=%0d run=%0d expected 6 4 6", gt_cnt, lt_cnt, max_eq_run);
        end
    endtask

    task automatic test_hold();
        {gt, lt, eq} = 3'b100; a = 4'd9; b = 4'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got() !== exp_v) begin
                errors++;
                $display("FAIL hold_cyc%0d ir=%0b ov=%0b got=%h expected 0 1 %h", i, in_ready, out_valid, got(), exp_v);
            end
        end
        handshake();
        in_valid = 1'b0;
        checks++;
        if (got() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL after_handshake counts=%h ov=%0b ir=%0b expected 0 0 1", got(), out_valid, in_ready);
        end
    endtask

    task automatic test_bad();
        send(3'b100, 4'd8, 4'd1);
        for (int i = 0; i < 3; i++) send(3'b001, 4'd5, 4'd5);
        send(3'b000, 4'd3, 4'd3);
        for (int i = 0; i < 2; i++) send(3'b001, 4'd6, 4'd6);
        send(3'b110, 4'd4, 4'd2);
        for (int i = 0; i < 8; i++) send(3'b010, 4'd1, 4'd9);
        model();
        checks++;
        if (out_valid !== 1'b1 || got() !== exp_v) begin
            errors++; $display("FAIL bad_summary ov=%0b got=%h expected 1 %h", out_valid, got(), exp_v);
        end
        checks++;
        if (bad_cnt !== 8'd2 || max_eq_run !== 8'd3) begin
            errors++; $display("FAIL bad_const bad=%0d run=%0d expected 2 3", bad_cnt, max_eq_run);
        end
        handshake();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) send(3'b010, 4'd0, 4'd4);
        {gt, lt, eq} = 3'b100; a = 4'd7; b = 4'd2;
        in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0; clr_q();
        checks++;
        if (got() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_state counts=%h ov=%0b ir=%0b expected 0 0 1", got(), out_valid, in_ready);
        end
        for (int i = 0; i < WIN - 1; i++) send(3'b001, 4'd2, 4'd2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_restart_early out_valid=%0b expected 0", out_valid);
        end
        send(3'b100, 4'd3, 4'd1);
        model();
        checks++;
        if (out_valid !== 1'b1 || got() !== exp_v) begin
            errors++; $display("FAIL clear_restart ov=%0b got=%h expected 1 %h", out_valid, got(), exp_v);
        end
        handshake();
    endtask

    task automatic test_mism();
        send(3'b100, 4'd4, 4'd9);
        checks++;
`ifdef CMP_MONITOR_CHECK_EN
        if (gt_cnt !== 8'd1 || mism_cnt !== 8'd1) begin
            errors++; $display("FAIL mism_hit gt=%0d mism=%0d expected 1 1", gt_cnt, mism_cnt);
        end
`else
        if (gt_cnt !== 8'd1 || mism_cnt !== 8'd0) begin
            errors++; $display("FAIL mism_off gt=%0d mism=%0d expected 1 0", gt_cnt, mism_cnt);
        end
`endif
        clear = 1'b1; tick(); clear = 1'b0; clr_q();
    endtask

    task automatic test_random();
        logic [3:0] va, vb;
        logic [2:0] f;
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < WIN; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                va = 4'($urandom_range(0, 15));
                vb = ($urandom_range(0, 3) == 0) ? va : 4'($urandom_range(0, 15));
                f  = ($urandom_range(0, 9) < 7) ? rel(va, vb) : 3'($urandom_range(0, 7));
                send(f, va, vb);
                if (i == 7) begin
                    model();
                    checks++;
                    if (got() !== exp_v || out_valid !== 1'b0) begin
                        errors++; $display("FAIL rand_partial w%0d got=%h ov=%0b expected %h 0", w, got(), out_valid, exp_v);
                    end
                end
            end
            model();
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (out_valid !== 1'b1 || got() !== exp_v) begin
                errors++; $display("FAIL rand_window w%0d ov=%0b got=%h expected 1 %h", w, out_valid, got(), exp_v);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_bad();
        test_clear();
        test_mism();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_result_window_monitor.md
Name: cmp_result_window_monitor

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its three result flags together with the A/B operands that produced them.
- Accumulates per-outcome counts over a fixed window of accepted samples.
- Presents the window summary on a valid/ready output handshake, holding it until it is consumed.
- Feeds status/scoreboard logic and lets the comparator run as a streamed sample source.

Parameters:
- WIN_LEN, 16: samples per window; legal range 1 to 255.
- CNT_W, 8: width of every result counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous abort of the current window.
- in_valid  in  1  sample present.
- in_ready  out  1  monitor can accept a sample.
- a  in  4  comparator operand A.
- b  in  4  comparator operand B.
- a_gt_b  in  1  comparator flag.
- a_lt_b  in  1  comparator flag.
- a_eq_b  in  1  comparator flag.
- gt_cnt  out  CNT_W  window count of gt results.
- lt_cnt  out  CNT_W  window count of lt results.
- eq_cnt  out  CNT_W  window count of eq results.
- bad_cnt  out  CNT_W  window count of non-one-hot flag samples.
- max_eq_run  out  CNT_W  longest run of consecutive eq samples in the window.
- mism_cnt  out  CNT_W  flag/operand mismatches (optional feature).
- out_valid  out  1  window summary valid.
- out_ready  in  1  consumer accepts the summary.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. No asynchronous reset anywhere.
- Reset values: all counters 0, max_eq_run 0, out_valid 0, in_ready 1, state IDLE.
- States:
  - IDLE: no sample in window yet.
  - ACC: window partially filled.
  - DONE: window complete, summary held.
- Accept condition: a sample is accepted on a cycle with in_valid && in_ready.
- in_ready: 1 in IDLE and ACC, 0 in DONE. It is a registered function of state only and never depends on in_valid.
- Classification of each accepted sample (exactly one applies):
  - Flags one-hot: increment gt_cnt, lt_cnt or eq_cnt.
  - Flags 000, or more than one flag set: increment bad_cnt.
- Equality runs: cur_run (internal) increments on an eq sample and resets to 0 on any other sample. max_eq_run = max(max_eq_run, new cur_run). A bad sample breaks the run.
- Sample counter: internal, width $clog2(WIN_LEN+1). Increments on every accepted sample, including bad ones.
- Transitions:
  - IDLE -> ACC on the first accepted sample.
  - ACC -> DONE on the cycle the WIN_LEN-th sample is accepted.
  - WIN_LEN = 1: IDLE -> DONE directly.
- Output latency: counters update one cycle after the accept edge. out_valid rises on the cycle after the last sample is accepted, with final counts already stable.
- DONE: outputs frozen while out_valid = 1 and out_ready = 0. On out_valid && out_ready, the next cycle has all counters and run registers at 0, out_valid 0, state IDLE, in_ready 1.
- No overlap: no sample is accepted in the handshake cycle.
- Saturation: every counter saturates at 2^CNT_W-1 and never wraps.
- clear:
  - From any state: next cycle equals the reset state. A partial or held window is discarded with no out_valid pulse.
  - clear in the same cycle as an accepted sample: clear wins and the sample is dropped.
  - clear in the same cycle as an output handshake: the result is the reset state.
- Priority: rst > clear > output handshake > sample accept.
- Outputs are registered with no combinational in-to-out paths. Counter outputs are visible in every state: running values in ACC, held values in DONE.

Optional Feature:
- Macro: CMP_MONITOR_CHECK_EN.
- Defined:
  - For every accepted sample whose flags are one-hot, recompute the relation from a and b (unsigned).
  - Increment mism_cnt (saturating) when the asserted flag disagrees with the recomputed relation.
  - mism_cnt is cleared with the other counters.
  - Classification counters still follow the flags, not the recomputation.
- Not defined: mism_cnt is tied to 0, a and b are unused, and no comparison logic is synthesised.

Test Plan:
- rst held 2 cycles, then released -> all counters 0, out_valid 0, in_ready 1; the first sample is accepted on the next cycle.
- WIN_LEN = 16, with 16 back-to-back samples: 6 gt (a=9, b=3), 4 lt (a=2, b=7), 6 eq in a row (a=b=5) -> out_valid one cycle after the 16th accept; gt 6, lt 4, eq 6, bad 0, max_eq_run 6.
- Window containing flags 000 and 110 once each, with eq runs of 3 and 2 split by a bad sample -> bad_cnt 2, max_eq_run 3, sample count still reaches 16.
- out_ready held 0 for 5 cycles in DONE while in_valid = 1 -> in_ready 0, counts unchanged, no extra accepts; after the handshake, all counts are 0 the next cycle.
- clear asserted after 7 accepted samples, with in_valid = 1 on the same cycle -> no out_valid; counters 0; the window restarts and needs 16 fresh samples.
- CMP_MONITOR_CHECK_EN defined, sample a=4, b=9 with flag a_gt_b=1 -> gt_cnt +1 and mism_cnt +1. Without the macro -> mism_cnt stays 0.
